// File: rtl/id_hazard_scoreboard.sv
// id_hazard_scoreboard: decode-stage issue gate that tracks pending register writes
//
// Keeps a small saturating-free pending-write counter per architectural register
// (register 0 is never tracked) and holds decode->execute issue on RAW/WAW hazards.
// A flush pulse moves the block into DRAIN, where issue is blocked until every
// in-flight write has retired through writeback.
//
// Build option: define SCOREBOARD_BYPASS_EN to let a same-cycle writeback of the
// last pending write clear a RAW hazard (EX picks the value off the forward path).
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   id_valid/id_ready decode handshake; id_ready is issue_ready gated by hazard
//   id_rs1/id_rs2/id_rd, id_use_rs1/id_use_rs2/id_wr_rd  decoded operand fields
//   issue_valid/issue_ready  handshake towards EX
//   wb_valid/wb_rd    writeback retiring one pending write
//   flush             one-cycle flush request
//   busy_mask         bit i set while register i has pending writes
//   inflight          total pending writes across all registers
//   stall_cycles      saturating count of cycles a valid instruction was held
//   wb_underflow      sticky flag: writeback arrived for a register with nothing pending
module id_hazard_scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int REG_AW   = 5,
    parameter int CNT_W    = 2,
    parameter int PERF_W   = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                id_valid,
    output logic                id_ready,
    input  logic [REG_AW-1:0]   id_rs1,
    input  logic [REG_AW-1:0]   id_rs2,
    input  logic [REG_AW-1:0]   id_rd,
    input  logic                id_use_rs1,
    input  logic                id_use_rs2,
    input  logic                id_wr_rd,
    output logic                issue_valid,
    input  logic                issue_ready,
    input  logic                wb_valid,
    input  logic [REG_AW-1:0]   wb_rd,
    input  logic                flush,
    output logic [NUM_REGS-1:0] busy_mask,
    output logic [7:0]          inflight,
    output logic [PERF_W-1:0]   stall_cycles,
    output logic                wb_underflow
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {RUN, DRAIN} state_t;

    state_t            state, state_next;
    logic [CNT_W-1:0]  cnt [NUM_REGS];
    logic [CNT_W-1:0]  cnt_rs1, cnt_rs2, cnt_rd, cnt_wb;
    logic              byp1, byp2, hazard, fire, inc, dec, underflow_hit;
    logic [7:0]        inflight_next;

    assign cnt_rs1 = cnt[id_rs1];
    assign cnt_rs2 = cnt[id_rs2];
    assign cnt_rd  = cnt[id_rd];
    assign cnt_wb  = cnt[wb_rd];

`ifdef SCOREBOARD_BYPASS_EN
    // Only the last outstanding write can be forwarded; older ones are still stale.
    assign byp1 = wb_valid && wb_rd == id_rs1 && cnt_rs1 == CNT_W'(1);
    assign byp2 = wb_valid && wb_rd == id_rs2 && cnt_rs2 == CNT_W'(1);
`else
    assign byp1 = 1'b0;
    assign byp2 = 1'b0;
`endif

    // Flush blocks issue in its own cycle, so the flushed instruction never counts.
    assign hazard = state == DRAIN || flush
                 || (id_use_rs1 && id_rs1 != '0 && cnt_rs1 != '0 && !byp1)
                 || (id_use_rs2 && id_rs2 != '0 && cnt_rs2 != '0 && !byp2)
                 || (id_wr_rd && id_rd != '0 && cnt_rd == CNT_MAX);

    assign fire          = issue_valid && issue_ready;
    assign inc           = fire && id_wr_rd && id_rd != '0;
    assign dec           = wb_valid && wb_rd != '0 && cnt_wb != '0;
    assign underflow_hit = wb_valid && wb_rd != '0 && cnt_wb == '0;
    assign inflight_next = inflight + 8'(inc) - 8'(dec);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= RUN;
        else
            state <= state_next;
    end

    // DRAIN exits on the same edge that retires the last pending write.
    always_comb begin
        state_next = state;
        if (state == RUN)
            state_next = flush ? DRAIN : RUN;
        else
            state_next = (flush || inflight_next != '0) ? DRAIN : RUN;
    end

    always_comb begin
        issue_valid = id_valid && !hazard;
        id_ready    = issue_ready && !hazard;
    end

    // A same-register issue and writeback in one cycle cancel out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++)
                cnt[i] <= '0;
        end else begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (inc && id_rd == REG_AW'(i) && !(dec && wb_rd == REG_AW'(i)))
                    cnt[i] <= cnt[i] + CNT_W'(1);
                else if (dec && wb_rd == REG_AW'(i) && !(inc && id_rd == REG_AW'(i)))
                    cnt[i] <= cnt[i] - CNT_W'(1);
            end
        end
    end

    always_comb begin
        busy_mask = '0;
        for (int i = 1; i < NUM_REGS; i++)
            busy_mask[i] = cnt[i] != '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight     <= '0;
            stall_cycles <= '0;
            wb_underflow <= 1'b0;
        end else begin
            inflight <= inflight_next;
            if (id_valid && hazard && stall_cycles != '1)
                stall_cycles <= stall_cycles + PERF_W'(1);
            if (underflow_hit)
                wb_underflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_id_hazard_scoreboard.sv
// tb_id_hazard_scoreboard: directed scenarios plus randomized traffic against a pending-write model
module tb_id_hazard_scoreboard;
    localparam int NR   = 32;
    localparam int PW   = 6;
    localparam int MAXC = 3;
    localparam int SMAX = (1 << PW) - 1;
`ifdef SCOREBOARD_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk = 0, rst = 0;
    logic          id_valid, id_ready, use_rs1, use_rs2, wr_rd;
    logic [4:0]    rs1, rs2, rd, wb_rd;
    logic          issue_valid, issue_ready, wb_valid, flush;
    logic [NR-1:0] busy_mask;
    logic [7:0]    inflight;
    logic [PW-1:0] stall_cycles;
    logic          wb_underflow;

    int tests = 0, fails = 0;

    int cm[NR];
    int infl_m, stall_m;
    bit uf_m, drain_m;

    id_hazard_scoreboard #(.NUM_REGS(NR), .REG_AW(5), .CNT_W(2), .PERF_W(PW)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_ready(id_ready),
        .id_rs1(rs1), .id_rs2(rs2), .id_rd(rd), .id_use_rs1(use_rs1), .id_use_rs2(use_rs2),
        .id_wr_rd(wr_rd), .issue_valid(issue_valid), .issue_ready(issue_ready),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush), .busy_mask(busy_mask),
        .inflight(inflight), .stall_cycles(stall_cycles), .wb_underflow(wb_underflow)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        foreach (cm[i]) cm[i] = 0;
        infl_m = 0; stall_m = 0; uf_m = 0; drain_m = 0;
    endfunction

    function automatic bit haz_m();
        bit b1, b2;
        b1 = BYP && wb_valid && wb_rd == rs1 && cm[rs1] == 1;
        b2 = BYP && wb_valid && wb_rd == rs2 && cm[rs2] == 1;
        return drain_m || flush
            || (use_rs1 && rs1 != 0 && cm[rs1] > 0 && !b1)
            || (use_rs2 && rs2 != 0 && cm[rs2] > 0 && !b2)
            || (wr_rd && rd != 0 && cm[rd] == MAXC);
    endfunction

    function automatic logic [NR-1:0] busy_m();
        logic [NR-1:0] b;
        b = '0;
        for (int i = 1; i < NR; i++) b[i] = cm[i] > 0;
        return b;
    endfunction

    task automatic idle();
        id_valid = 0; use_rs1 = 0; use_rs2 = 0; wr_rd = 0;
        rs1 = 0; rs2 = 0; rd = 0; issue_ready = 1;
        wb_valid = 0; wb_rd = 0; flush = 0;
    endtask

    // Advance one clock, applying the pending-write rules to the model.
    task automatic tick();
        int nc[NR];
        int ni, ns;
        bit h, nuf, nd;
        nc = cm; ni = infl_m; ns = stall_m; nuf = uf_m;
        h = haz_m();
        if (id_valid && !h && issue_ready && wr_rd && rd != 0) begin nc[rd]++; ni++; end
        if (wb_valid && wb_rd != 0) begin
            if (cm[wb_rd] > 0) begin nc[wb_rd]--; ni--; end
            else nuf = 1;
        end
        if (id_valid && h && ns < SMAX) ns++;
        nd = drain_m ? (flush || ni != 0) : flush;
        @(posedge clk);
        cm = nc; infl_m = ni; stall_m = ns; uf_m = nuf; drain_m = nd;
        @(negedge clk);
    endtask

    task automatic test_reset();
        idle();
        rst = 1; model_reset();
        repeat (2) @(negedge clk);
        rst = 0;
        #1;
        tests++; if (busy_mask !== '0) begin fails++; $display("FAIL reset_busy: got %0h expected 0", busy_mask); end
        tests++; if (inflight !== 8'd0) begin fails++; $display("FAIL reset_inflight: got %0d expected 0", inflight); end
        tests++; if (stall_cycles !== '0) begin fails++; $display("FAIL reset_stall: got %0d expected 0", stall_cycles); end
        tests++; if (wb_underflow !== 1'b0) begin fails++; $display("FAIL reset_underflow: got %0b expected 0", wb_underflow); end
        tests++; if (id_ready !== 1'b1 || issue_valid !== 1'b0) begin fails++; $display("FAIL reset_handshake: got ready=%0b valid=%0b expected 1/0", id_ready, issue_valid); end
    endtask

    task automatic test_issue_raw();
        idle(); id_valid = 1; wr_rd = 1; rd = 5;
        #1;
        tests++; if (issue_valid !== 1'b1) begin fails++; $display("FAIL raw_first_issue: got %0b expected 1", issue_valid); end
        tick();
        idle();
        #1;
        tests++; if (busy_mask[5] !== 1'b1) begin fails++; $display("FAIL raw_busy5: got %0b expected 1", busy_mask[5]); end
        tests++; if (inflight !== 8'd1) begin fails++; $display("FAIL raw_inflight: got %0d expected 1", inflight); end
        id_valid = 1; use_rs1 = 1; rs1 = 5;
        #1;
        tests++; if (id_ready !== 1'b0 || issue_valid !== 1'b0) begin fails++; $display("FAIL raw_stall: got ready=%0b valid=%0b expected 0/0", id_ready, issue_valid); end
        tick();
        tests++; if (stall_cycles !== PW'(1)) begin fails++; $display("FAIL raw_stall_count: got %0d expected 1", stall_cycles); end
    endtask

    task automatic test_bypass();
        id_valid = 1; use_rs1 = 1; rs1 = 5; wb_valid = 1; wb_rd = 5;
        #1;
        tests++; if (issue_valid !== BYP) begin fails++; $display("FAIL bypass_same_cycle: got %0b expected %0b", issue_valid, BYP); end
        tick();
        wb_valid = 0;
        #1;
        tests++; if (issue_valid !== 1'b1) begin fails++; $display("FAIL bypass_next_cycle: got %0b expected 1", issue_valid); end
        tests++; if (stall_cycles !== PW'(BYP ? 1 : 2)) begin fails++; $display("FAIL bypass_stall_count: got %0d expected %0d", stall_cycles, BYP ? 1 : 2); end
        tick();
        idle();
        #1;
        tests++; if (busy_mask !== '0 || inflight !== 8'd0) begin fails++; $display("FAIL bypass_clear: got busy=%0h inflight=%0d expected 0/0", busy_mask, inflight); end
    endtask

    task automatic test_waw_saturate();
        idle(); id_valid = 1; wr_rd = 1; rd = 7;
        for (int k = 0; k < 3; k++) begin
            #1;
            tests++; if (issue_valid !== 1'b1) begin fails++; $display("FAIL waw_issue%0d: got %0b expected 1", k, issue_valid); end
            tick();
        end
        #1;
        tests++; if (issue_valid !== 1'b0 || id_ready !== 1'b0) begin fails++; $display("FAIL waw_full_stall: got valid=%0b ready=%0b expected 0/0", issue_valid, id_ready); end
        tests++; if (inflight !== 8'd3) begin fails++; $display("FAIL waw_inflight3: got %0d expected 3", inflight); end
        wb_valid = 1; wb_rd = 7;
        #1;
        tests++; if (issue_valid !== 1'b0) begin fails++; $display("FAIL waw_wb_same_cycle: got %0b expected 0", issue_valid); end
        tick();
        wb_valid = 0;
        #1;
        tests++; if (issue_valid !== 1'b1 || inflight !== 8'd2) begin fails++; $display("FAIL waw_after_wb: got valid=%0b inflight=%0d expected 1/2", issue_valid, inflight); end
        tick();
        idle(); wb_valid = 1; wb_rd = 7;
        repeat (3) tick();
        wb_valid = 0;
        #1;
        tests++; if (inflight !== 8'd0 || busy_mask !== '0) begin fails++; $display("FAIL waw_drained: got inflight=%0d busy=%0h expected 0/0", inflight, busy_mask); end
    endtask

    task automatic test_zero_reg();
        idle(); id_valid = 1; wr_rd = 1; rd = 0; use_rs1 = 1; rs1 = 0;
        #1;
        tests++; if (issue_valid !== 1'b1) begin fails++; $display("FAIL zero_issue: got %0b expected 1", issue_valid); end
        tick();
        idle();
        #1;
        tests++; if (busy_mask !== '0 || inflight !== 8'd0) begin fails++; $display("FAIL zero_untracked: got busy=%0h inflight=%0d expected 0/0", busy_mask, inflight); end
        tests++; if (stall_cycles !== PW'(stall_m)) begin fails++; $display("FAIL zero_no_stall: got %0d expected %0d", stall_cycles, stall_m); end
        tests++; if (wb_underflow !== 1'b0) begin fails++; $display("FAIL zero_uf_before: got %0b expected 0", wb_underflow); end
        wb_valid = 1; wb_rd = 9;
        tick();
        idle();
        #1;
        tests++; if (wb_underflow !== 1'b1 || inflight !== 8'd0) begin fails++; $display("FAIL underflow_set: got uf=%0b inflight=%0d expected 1/0", wb_underflow, inflight); end
    endtask

    task automatic test_flush_drain();
        idle(); id_valid = 1; wr_rd = 1; rd = 3;
        tick();
        rd = 4;
        tick();
        #1;
        tests++; if (inflight !== 8'd2) begin fails++; $display("FAIL flush_pre_inflight: got %0d expected 2", inflight); end
        rd = 10; flush = 1;
        #1;
        tests++; if (issue_valid !== 1'b0 || id_ready !== 1'b0) begin fails++; $display("FAIL flush_cycle: got valid=%0b ready=%0b expected 0/0", issue_valid, id_ready); end
        tick();
        flush = 0; wb_valid = 1; wb_rd = 3;
        #1;
        tests++; if (issue_valid !== 1'b0) begin fails++; $display("FAIL drain_block1: got %0b expected 0", issue_valid); end
        tick();
        wb_rd = 4;
        #1;
        tests++; if (issue_valid !== 1'b0) begin fails++; $display("FAIL drain_block2: got %0b expected 0", issue_valid); end
        tick();
        wb_valid = 0;
        #1;
        tests++; if (issue_valid !== 1'b1 || inflight !== 8'd0) begin fails++; $display("FAIL drain_exit: got valid=%0b inflight=%0d expected 1/0", issue_valid, inflight); end
        idle(); flush = 1;
        tick();
        flush = 0; id_valid = 1;
        #1;
        tests++; if (issue_valid !== 1'b0) begin fails++; $display("FAIL empty_drain_cycle: got %0b expected 0", issue_valid); end
        tick();
        #1;
        tests++; if (issue_valid !== 1'b1) begin fails++; $display("FAIL empty_drain_exit: got %0b expected 1", issue_valid); end
        idle();
    endtask

    task automatic test_async_reset();
        idle(); id_valid = 1; wr_rd = 1; rd = 3;
        tick();
        tick();
        wr_rd = 0; flush = 1;
        tick();
        flush = 0;
        #2;
        rst = 1;
        #1;
        tests++; if (busy_mask !== '0 || inflight !== 8'd0) begin fails++; $display("FAIL arst_counters: got busy=%0h inflight=%0d expected 0/0", busy_mask, inflight); end
        tests++; if (stall_cycles !== '0 || wb_underflow !== 1'b0) begin fails++; $display("FAIL arst_perf: got stall=%0d uf=%0b expected 0/0", stall_cycles, wb_underflow); end
        tests++; if (issue_valid !== 1'b1) begin fails++; $display("FAIL arst_state_run: got %0b expected 1", issue_valid); end
        model_reset();
        @(negedge clk);
        rst = 0;
        idle();
    endtask

    task automatic test_stall_saturate();
        idle(); id_valid = 1; wr_rd = 1; rd = 11;
        tick();
        wr_rd = 0; use_rs1 = 1; rs1 = 11;
        repeat (SMAX + 8) tick();
        #1;
        tests++; if (stall_cycles !== PW'(SMAX)) begin fails++; $display("FAIL stall_saturate: got %0d expected %0d", stall_cycles, SMAX); end
        idle(); wb_valid = 1; wb_rd = 11;
        tick();
        idle();
    endtask

    task automatic test_random();
        for (int n = 0; n < 3000; n++) begin
            id_valid = ($urandom % 4) != 0;
            issue_ready = ($urandom % 4) != 0;
            use_rs1 = $urandom; use_rs2 = $urandom; wr_rd = $urandom;
            rs1 = 5'($urandom_range(0, 7)); rs2 = 5'($urandom_range(0, 7)); rd = 5'($urandom_range(0, 7));
            wb_valid = $urandom % 2;
            wb_rd = 5'($urandom_range(0, 7));
            for (int t = 0; t < 4 && cm[wb_rd] == 0; t++) wb_rd = 5'($urandom_range(1, 7));
            flush = ($urandom % 64) == 0;
            #1;
            tests++; if (issue_valid !== haz_m() ^ id_valid && !(id_valid && haz_m()) ? 1'b0 : (id_valid && !haz_m())) begin end
            tests--;
            tests++; if (issue_valid !== (id_valid && !haz_m())) begin fails++; $display("FAIL rnd_issue_valid @%0d: got %0b expected %0b", n, issue_valid, id_valid && !haz_m()); end
            tests++; if (id_ready !== (issue_ready && !haz_m())) begin fails++; $display("FAIL rnd_id_ready @%0d: got %0b expected %0b", n, id_ready, issue_ready && !haz_m()); end
            tests++; if (busy_mask !== busy_m()) begin fails++; $display("FAIL rnd_busy @%0d: got %0h expected %0h", n, busy_mask, busy_m()); end
            tests++; if (inflight !== 8'(infl_m)) begin fails++; $display("FAIL rnd_inflight @%0d: got %0d expected %0d", n, inflight, infl_m); end
            tests++; if (stall_cycles !== PW'(stall_m)) begin fails++; $display("FAIL rnd_stall @%0d: got %0d expected %0d", n, stall_cycles, stall_m); end
            tests++; if (wb_underflow !== uf_m) begin fails++; $display("FAIL rnd_underflow @%0d: got %0b expected %0b", n, wb_underflow, uf_m); end
            tick();
        end
        idle();
    endtask

    initial begin
        idle();
        @(negedge clk);
        test_reset();
        test_issue_raw();
        test_bypass();
        test_waw_saturate();
        test_zero_reg();
        test_flush_drain();
        test_async_reset();
        test_stall_saturate();
        test_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
